// File: rtl/pc_sequencer_if.sv
// Handshake bundle between the pc_sequencer and its neighbours: the execute
// redirect requester, the fetch advance requester and the PC increment port.
// The slave modport is the sequencer's view; master is the environment side.
interface pc_sequencer_if #(
  parameter int XLEN = 32
);
  logic            i_redir_valid;
  logic            o_redir_ready;
  logic [1:0]      i_redir_op;
  logic [XLEN-1:0] i_redir_data;
  logic            i_adv_valid;
  logic            o_adv_ready;
  logic            i_stall;
  logic            o_incr_valid;
  logic            i_incr_ready;
  logic [1:0]      o_incr_op;
  logic [XLEN-1:0] o_incr_data;
  logic            o_flush;
  logic            o_err;

  modport slave (
    input  i_redir_valid, i_redir_op, i_redir_data, i_adv_valid, i_stall, i_incr_ready,
    output o_redir_ready, o_adv_ready, o_incr_valid, o_incr_op, o_incr_data, o_flush, o_err
  );

  modport master (
    output i_redir_valid, i_redir_op, i_redir_data, i_adv_valid, i_stall, i_incr_ready,
    input  o_redir_ready, o_adv_ready, o_incr_valid, o_incr_op, o_incr_data, o_flush, o_err
  );
endinterface

// File: rtl/pc_sequencer.sv
// Program-counter update sequencer for the rv32i core. Redirects from execute
// win over sequential advances from fetch; every accepted request becomes one
// registered command on the PC increment port. After a redirect, advances are
// blanked for FLUSH_CYCLES cycles and a one-cycle flush pulse is raised so the
// wrong-path fetches get discarded. The interface XLEN must match XLEN here.
module pc_sequencer #(
  parameter int XLEN         = 32,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic            clk,
  input  logic            rstn,
  pc_sequencer_if.slave   bus
);

  localparam logic [1:0] PC_INCR   = 2'b00;
  localparam logic [1:0] PC_JUMP   = 2'b01;
  localparam logic [1:0] PC_BRANCH = 2'b10;
  localparam logic [1:0] PC_RSVD   = 2'b11;

  localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    FLUSH = 2'b10
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [3:0]      flush_cnt;
  logic [3:0]      flush_cnt_nxt;

  logic            incr_valid_q;
  logic [1:0]      incr_op_q;
  logic [XLEN-1:0] incr_data_q;
  logic            flush_q;
  logic            err_q;

  logic            redir_ready;
  logic            adv_ready;
  logic            slot_free;
  logic            redir_acc;
  logic            redir_rsvd;
  logic            redir_take;
  logic            adv_acc;

  // The slot can take a new command when it is empty or draining this cycle.
  assign slot_free  = !incr_valid_q | bus.i_incr_ready;
  assign redir_acc  = bus.i_redir_valid & redir_ready;
  assign redir_rsvd = (bus.i_redir_op == PC_RSVD);
  assign redir_take = redir_acc & !redir_rsvd;
  assign adv_acc    = bus.i_adv_valid & adv_ready;

  // State register and flush-window counter.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      flush_cnt <= 4'd0;
    end else begin
      state     <= state_nxt;
      flush_cnt <= flush_cnt_nxt;
    end
  end

  // Next state: any flushing redirect (re)opens the blanking window, which
  // counts down regardless of stall and hands back to RUN on its last cycle.
  always_comb begin
    state_nxt     = state;
    flush_cnt_nxt = flush_cnt;
    case (state)
      IDLE: begin
        state_nxt = RUN;
      end
      RUN, FLUSH: begin
        if (redir_take) begin
          if (FLUSH_LOAD == 4'd0) begin
            state_nxt     = RUN;
            flush_cnt_nxt = 4'd0;
          end else begin
            state_nxt     = FLUSH;
            flush_cnt_nxt = FLUSH_LOAD;
          end
        end else if (state == FLUSH) begin
          if (flush_cnt <= 4'd1) begin
            state_nxt     = RUN;
            flush_cnt_nxt = 4'd0;
          end else begin
            flush_cnt_nxt = flush_cnt - 4'd1;
          end
        end
      end
      default: begin
        state_nxt     = IDLE;
        flush_cnt_nxt = 4'd0;
      end
    endcase
  end

  // Request readies: redirects are blocked only in IDLE, advances also during
  // the flush window and whenever a redirect is being offered.
  always_comb begin
    redir_ready = (state != IDLE) & slot_free & !bus.i_stall;
    adv_ready   = (state == RUN) & slot_free & !bus.i_stall & !bus.i_redir_valid;
  end

  // Output slot: loads on acceptance, holds while the PC is not ready, and
  // empties once its command handshakes with nothing new behind it.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      incr_valid_q <= 1'b0;
      incr_op_q    <= PC_INCR;
      incr_data_q  <= '0;
      flush_q      <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      flush_q <= redir_take;
      err_q   <= redir_acc & redir_rsvd;
      if (redir_take) begin
        incr_valid_q <= 1'b1;
        incr_op_q    <= bus.i_redir_op;
        incr_data_q  <= (bus.i_redir_op == PC_JUMP || bus.i_redir_op == PC_BRANCH) ?
                        bus.i_redir_data : '0;
      end else if (adv_acc) begin
        incr_valid_q <= 1'b1;
        incr_op_q    <= PC_INCR;
        incr_data_q  <= '0;
      end else if (slot_free) begin
        incr_valid_q <= 1'b0;
      end
    end
  end

  assign bus.o_redir_ready = redir_ready;
  assign bus.o_adv_ready   = adv_ready;
  assign bus.o_incr_valid  = incr_valid_q;
  assign bus.o_incr_op     = incr_op_q;
  assign bus.o_incr_data   = incr_data_q;
  assign bus.o_flush       = flush_q;
  assign bus.o_err         = err_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Testbench for pc_sequencer: directed scenarios followed by random traffic.
// Expected commands go into a queue and are compared by an independent
// monitor whenever the DUT presents a command on the increment port.
module tb_pc_sequencer;

  localparam int XLEN = 32;
  localparam int F    = 2;

  logic clk  = 1'b0;
  logic rstn = 1'b0;

  pc_sequencer_if #(.XLEN(XLEN)) bus ();

  pc_sequencer #(.XLEN(XLEN), .FLUSH_CYCLES(F)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: commands awaiting delivery plus a cycle-based view of
  // the blanking window (cycles elapsed since the last flushing redirect).
  logic [33:0] cmd_q[$];
  int          cyc;
  int          last_redir;
  bit          pending;
  bit          exp_flush;
  bit          exp_err;

  // Free-running clock.
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s got=%h want=%h at %0t", name, got, want, $time);
    end
  endtask

  task automatic drive(input bit rv, input logic [1:0] op, input logic [31:0] d,
                       input bit av, input bit st, input bit ir);
    bus.i_redir_valid = rv;
    bus.i_redir_op    = op;
    bus.i_redir_data  = d;
    bus.i_adv_valid   = av;
    bus.i_stall       = st;
    bus.i_incr_ready  = ir;
  endtask

  // Mid-cycle comparison of readies and pulses, then model update for this cycle.
  task automatic checkOutput();
    bit slot_free;
    bit e_rr;
    bit e_ar;
    bit racc;
    bit aacc;
    @(negedge clk);
    #2;
    slot_free = !pending || bus.i_incr_ready;
    e_rr = (cyc > 0) && slot_free && !bus.i_stall;
    e_ar = (cyc > 0) && (cyc - last_redir >= F + 1) && slot_free && !bus.i_stall && !bus.i_redir_valid;
    check("redir_ready", bus.o_redir_ready, e_rr);
    check("adv_ready",   bus.o_adv_ready,   e_ar);
    check("flush",       bus.o_flush,       exp_flush);
    check("err",         bus.o_err,         exp_err);
    racc = bus.i_redir_valid && e_rr;
    aacc = bus.i_adv_valid && e_ar;
    exp_flush = racc && (bus.i_redir_op != 2'b11);
    exp_err   = racc && (bus.i_redir_op == 2'b11);
    if (exp_flush) begin
      cmd_q.push_back({bus.i_redir_op, (bus.i_redir_op == 2'b00) ? 32'h0 : bus.i_redir_data});
      last_redir = cyc;
      pending = 1'b1;
    end else if (aacc) begin
      cmd_q.push_back({2'b00, 32'h0});
      pending = 1'b1;
    end else begin
      pending = pending && !bus.i_incr_ready;
    end
    cyc++;
  endtask

  task automatic applyStimulus(input bit rv, input logic [1:0] op, input logic [31:0] d,
                               input bit av, input bit st, input bit ir);
    @(posedge clk);
    #1;
    drive(rv, op, d, av, st, ir);
    checkOutput();
  endtask

  // Asynchronous reset in mid-cycle, release just after an edge, IDLE cycle checked.
  task automatic resetDut(input bit av, input bit ir);
    @(posedge clk);
    #3;
    rstn = 1'b0;
    #1;
    check("rst_incr_valid", bus.o_incr_valid,  1'b0);
    check("rst_incr_op",    bus.o_incr_op,     2'b00);
    check("rst_incr_data",  bus.o_incr_data,   32'h0);
    check("rst_flush",      bus.o_flush,       1'b0);
    check("rst_err",        bus.o_err,         1'b0);
    check("rst_redir_rdy",  bus.o_redir_ready, 1'b0);
    check("rst_adv_rdy",    bus.o_adv_ready,   1'b0);
    cmd_q.delete();
    pending    = 1'b0;
    exp_flush  = 1'b0;
    exp_err    = 1'b0;
    last_redir = -1000;
    cyc        = 0;
    @(posedge clk);
    #1;
    rstn = 1'b1;
    drive(1'b0, 2'b00, 32'h0, av, 1'b0, ir);
    checkOutput();
  endtask

  // Monitor: the command on the port must match the oldest expected one and
  // hold until the PC accepts it.
  initial begin
    forever begin
      @(negedge clk);
      if (rstn) begin
        check("incr_valid", bus.o_incr_valid, (cmd_q.size() != 0));
        if (bus.o_incr_valid && cmd_q.size() != 0) begin
          check("incr_op",   bus.o_incr_op,   cmd_q[0][33:32]);
          check("incr_data", bus.o_incr_data, cmd_q[0][31:0]);
          if (bus.i_incr_ready) void'(cmd_q.pop_front());
        end
      end
    end
  end

  initial begin
    drive(1'b0, 2'b00, 32'h0, 1'b0, 1'b0, 1'b1);
    last_redir = -1000;
    cyc = 0;
    pending = 1'b0;
    exp_flush = 1'b0;
    exp_err = 1'b0;

    // Reset release with continuous advances.
    resetDut(1'b1, 1'b1);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 2'b00, 32'h0, 1'b1, 1'b0, 1'b1);

    // Simultaneous jump and advance, then the blanking window.
    applyStimulus(1'b1, 2'b01, 32'h0000_0100, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 2'b00, 32'h0, 1'b1, 1'b0, 1'b1);

    // Branch held three cycles by a busy PC.
    applyStimulus(1'b1, 2'b10, 32'hFFFF_FFF8, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 2'b01, 32'h0000_0200, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 2'b00, 32'h0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 2'b00, 32'h0, 1'b0, 1'b0, 1'b1);

    // Reserved redirect: error pulse, no flush, advance accepted right after.
    applyStimulus(1'b1, 2'b11, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b1);
    applyStimulus(1'b0, 2'b00, 32'h0, 1'b1, 1'b0, 1'b1);
    applyStimulus(1'b0, 2'b00, 32'h0, 1'b0, 1'b0, 1'b1);

    // PcIncr redirect, stall through the window, then advances resume.
    applyStimulus(1'b1, 2'b00, 32'h1234_5678, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 2'b01, 32'h0000_0300, 1'b1, 1'b1, 1'b1);
    applyStimulus(1'b1, 2'b01, 32'h0000_0300, 1'b1, 1'b1, 1'b1);
    applyStimulus(1'b0, 2'b00, 32'h0, 1'b1, 1'b0, 1'b1);

    // Second redirect inside the window restarts it.
    applyStimulus(1'b1, 2'b01, 32'h0000_0400, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 2'b10, 32'h0000_0010, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 2'b00, 32'h0, 1'b1, 1'b0, 1'b1);

    // Reset while a command is pending and the window is open.
    applyStimulus(1'b1, 2'b01, 32'h0000_0500, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 2'b00, 32'h0, 1'b1, 1'b0, 1'b0);
    resetDut(1'b1, 1'b1);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 2'b00, 32'h0, 1'b1, 1'b0, 1'b1);

    // Random traffic with one reset in the middle.
    for (int i = 0; i < 600; i++) begin
      if (i == 300) resetDut(1'b1, 1'b1);
      applyStimulus(($urandom % 4) == 0, 2'($urandom % 4), $urandom,
                    ($urandom % 4) != 0, ($urandom % 8) == 0, ($urandom % 4) != 0);
    end

    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 2'b00, 32'h0, 1'b0, 1'b0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
